mem_dump_ctrl: RTL

MEM_DUMP_CTRL -- requirements
Module: mem_dump_ctrl

---
 rtl/mem_dump_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mem_dump_ctrl.sv
// End-of-run data memory dump controller: freezes the CPU, then streams
// every word out over a valid/ready port. Optional: DUMP_SKIP_ZERO_EN.
module mem_dump_ctrl #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 10,
  parameter int DEPTH   = 1024,
  parameter int TIMEOUT = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              halt_i,
  output logic              cpu_stall_o,
  output logic              mem_rd_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic [ADDR_W-1:0] dump_addr_o,
  output logic [DATA_W-1:0] dump_data_o,
  output logic              done_o,
  output logic              timeout_o,
  output logic [31:0]       cycle_cnt_o
);

  typedef enum logic [2:0] {
    S_RUN,
    S_READ,
    S_CAPT,
    S_EMIT,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
  localparam logic [31:0]       TO_LAST = 32'(TIMEOUT - 1);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_ptr;
  logic                r_stall;
  logic                r_rd_en;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic                r_valid;
  logic [ADDR_W-1:0]   r_daddr;
  logic [DATA_W-1:0]   r_ddata;
  logic                r_done;
  logic                r_timeout;
  logic [31:0]         r_cnt;

  logic                w_last;
  logic [ADDR_W-1:0]   w_ptr_nx;
  logic                w_skip;

  assign w_last   = (r_ptr == LAST);
  assign w_ptr_nx = r_ptr + ADDR_W'(1);

`ifdef DUMP_SKIP_ZERO_EN
  assign w_skip = (mem_rdata_i == '0);
`else
  assign w_skip = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_RUN;
      r_ptr      <= '0;
      r_stall    <= 1'b0;
      r_rd_en    <= 1'b0;
      r_mem_addr <= '0;
      r_valid    <= 1'b0;
      r_daddr    <= '0;
      r_ddata    <= '0;
      r_done     <= 1'b0;
      r_timeout  <= 1'b0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          // halt has priority over a coincident timeout
          if (halt_i || r_cnt == TO_LAST) begin
            r_state    <= S_READ;
            r_ptr      <= '0;
            r_stall    <= 1'b1;
            r_rd_en    <= 1'b1;
            r_mem_addr <= '0;
            r_timeout  <= !halt_i;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_READ: begin
          r_rd_en <= 1'b0;
          r_state <= S_CAPT;
        end
        S_CAPT: begin
          r_ddata <= mem_rdata_i;
          r_daddr <= r_ptr;
          if (!w_skip) begin
            r_valid <= 1'b1;
            r_state <= S_EMIT;
          end else if (w_last) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_ptr      <= w_ptr_nx;
            r_mem_addr <= w_ptr_nx;
            r_rd_en    <= 1'b1;
            r_state    <= S_READ;
          end
        end
        S_EMIT: begin
          if (dump_ready_i) begin
            r_valid <= 1'b0;
            if (w_last) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_ptr      <= w_ptr_nx;
              r_mem_addr <= w_ptr_nx;
              r_rd_en    <= 1'b1;
              r_state    <= S_READ;
            end
          end
        end
        S_DONE: begin
          r_state <= S_DONE;
        end
        default: begin
          r_state <= S_RUN;
        end
      endcase
    end
  end

  assign cpu_stall_o  = r_stall;
  assign mem_rd_en_o  = r_rd_en;
  assign mem_addr_o   = r_mem_addr;
  assign dump_valid_o = r_valid;
  assign dump_addr_o  = r_daddr;
  assign dump_data_o  = r_ddata;
  assign done_o       = r_done;
  assign timeout_o    = r_timeout;
  assign cycle_cnt_o  = r_cnt;

endmodule
